// File: rtl/autocat_waymask_calc_if.sv
// AutoCAT waymask calculator bus: sorted counters and request in,
// busy / result pulse / waymask / way count out.
interface autocat_waymask_calc_if #(
    parameter int CACHE_ASSOCIATIVITY = 16,
    parameter int COUNTER_WIDTH       = 32
);
    localparam int NW = $clog2(CACHE_ASSOCIATIVITY) + 1;

    logic [CACHE_ASSOCIATIVITY*COUNTER_WIDTH-1:0] sorted_counter_flatted_in;
    logic                                         request_valid_in;
    logic                                         busy_out;
    logic                                         waymask_valid_out;
    logic [CACHE_ASSOCIATIVITY-1:0]               suggested_waymask_out;
    logic [NW-1:0]                                num_ways_out;

    modport master (
        output sorted_counter_flatted_in,
        output request_valid_in,
        input  busy_out,
        input  waymask_valid_out,
        input  suggested_waymask_out,
        input  num_ways_out
    );

    modport slave (
        input  sorted_counter_flatted_in,
        input  request_valid_in,
        output busy_out,
        output waymask_valid_out,
        output suggested_waymask_out,
        output num_ways_out
    );
endinterface

// File: rtl/autocat_waymask_calc.sv
// AutoCAT waymask calculator: sequential sum/scan over sorted hit counters.
// Optional macro AUTOCAT_WAYMASK_HYSTERESIS_EN suppresses one-way changes.
module autocat_waymask_calc #(
    parameter int CACHE_ASSOCIATIVITY = 16,
    parameter int COUNTER_WIDTH       = 32,
    parameter int THRESHOLD_NUM       = 15,
    parameter int MIN_WAYS            = 1
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    autocat_waymask_calc_if.slave  bus
);
    localparam int A  = CACHE_ASSOCIATIVITY;
    localparam int CN = COUNTER_WIDTH;
    localparam int IW = $clog2(A);
    localparam int AW = CN + IW;
    localparam int CW = AW + 5;
    localparam int NW = IW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUM,
        S_SCAN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [A*CN-1:0] r_snap;
    logic [IW-1:0]   r_idx;
    logic [AW-1:0]   r_total;
    logic [AW-1:0]   r_running;
    logic [A-1:0]    r_mask;
    logic [NW-1:0]   r_num;
    logic            r_valid;

    logic [CN-1:0]   w_elem;
    logic [AW-1:0]   w_running_nxt;
    logic [CW-1:0]   w_lhs;
    logic [CW-1:0]   w_rhs;
    logic            w_last;
    logic            w_zero;
    logic            w_term;
    logic [NW-1:0]   w_k_raw;
    logic [NW-1:0]   w_k;
    logic [A:0]      w_mask_full;
    logic [NW-1:0]   w_dist;
    logic            w_update;

    assign w_elem        = r_snap[r_idx*CN +: CN];
    assign w_running_nxt = r_running + AW'(w_elem);
    assign w_lhs         = CW'(w_running_nxt) << 4;
    assign w_rhs         = CW'(r_total) * CW'(THRESHOLD_NUM);
    assign w_last        = (r_idx == IW'(A - 1));
    assign w_zero        = (r_total == '0);
    assign w_term        = w_zero || (w_lhs >= w_rhs) || w_last;

    // Empty history: give the workload the whole cache.
    assign w_k_raw = w_zero ? NW'(A) : NW'(r_idx) + NW'(1);
    assign w_k     = (w_k_raw < NW'(MIN_WAYS)) ? NW'(MIN_WAYS) : w_k_raw;

    // Extra top bit lets k == A produce an all-ones mask.
    assign w_mask_full = ((A+1)'(1) << w_k) - (A+1)'(1);

    assign w_dist = (w_k > r_num) ? (w_k - r_num) : (r_num - w_k);

`ifdef AUTOCAT_WAYMASK_HYSTERESIS_EN
    assign w_update = (w_dist >= NW'(2));
`else
    assign w_update = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (bus.request_valid_in) w_state_nxt = S_SUM;
            S_SUM:  if (w_last)               w_state_nxt = S_SCAN;
            S_SCAN: if (w_term)               w_state_nxt = S_DONE;
            S_DONE:                           w_state_nxt = S_IDLE;
            default:                          w_state_nxt = S_IDLE;
        endcase
    end

    // Snapshot, accumulators and result registers; the result is
    // written on the edge entering DONE so it is visible in DONE.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_snap    <= '0;
            r_idx     <= '0;
            r_total   <= '0;
            r_running <= '0;
            r_mask    <= '1;
            r_num     <= NW'(A);
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.request_valid_in) begin
                        r_snap    <= bus.sorted_counter_flatted_in;
                        r_total   <= '0;
                        r_running <= '0;
                        r_idx     <= '0;
                    end
                end
                S_SUM: begin
                    r_total <= r_total + AW'(w_elem);
                    r_idx   <= w_last ? '0 : r_idx + IW'(1);
                end
                S_SCAN: begin
                    r_running <= w_running_nxt;
                    r_idx     <= r_idx + IW'(1);
                    if (w_term) begin
                        r_valid <= 1'b1;
                        if (w_update) begin
                            r_mask <= w_mask_full[A-1:0];
                            r_num  <= w_k;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_out              = (r_state != S_IDLE);
    assign bus.waymask_valid_out     = r_valid;
    assign bus.suggested_waymask_out = r_mask;
    assign bus.num_ways_out          = r_num;
endmodule

// File: tb/tb_autocat_waymask_calc.sv
// Directed bench for autocat_waymask_calc with default parameters.
// Expected values are hand-computed per scenario.
module tb_autocat_waymask_calc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    autocat_waymask_calc_if #(
        .CACHE_ASSOCIATIVITY(16),
        .COUNTER_WIDTH(32)
    ) bus ();

    autocat_waymask_calc #(
        .CACHE_ASSOCIATIVITY(16),
        .COUNTER_WIDTH(32),
        .THRESHOLD_NUM(15),
        .MIN_WAYS(1)
    ) dut (
        .clk_in(clk),
        .reset_in(rst_n),
        .bus(bus)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic set_all(input int unsigned v);
        for (int i = 0; i < 16; i++)
            bus.sorted_counter_flatted_in[i*32 +: 32] = v;
    endtask

    task automatic set_one(input int idx, input int unsigned v);
        bus.sorted_counter_flatted_in[idx*32 +: 32] = v;
    endtask

    // Issue one request and watch 40 cycles after the sampling edge.
    task automatic run(input string tag,
                       input int exp_cyc,
                       input logic [15:0] exp_mask,
                       input logic [4:0] exp_num,
                       input bit poke);
        int first;
        int pulses;
        first  = -1;
        pulses = 0;
        @(negedge clk);
        bus.request_valid_in = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) bus.request_valid_in = 1'b0;
            if (bus.waymask_valid_out === 1'b1) begin
                pulses++;
                if (first < 0) first = n;
            end
            if (poke && n == 5) begin
                bus.request_valid_in = 1'b1;
                set_all(10);
            end
            if (poke && n == 6) bus.request_valid_in = 1'b0;
        end
        check({tag, ".pulses"}, pulses, 1);
        check({tag, ".cycle"},  first,  exp_cyc);
        check({tag, ".mask"},   {16'h0, bus.suggested_waymask_out},
              {16'h0, exp_mask});
        check({tag, ".num"},    {27'h0, bus.num_ways_out},
              {27'h0, exp_num});
        check({tag, ".idle"},   {31'h0, bus.busy_out}, 32'h0);
    endtask

    initial begin : main
        int pulses;
        logic [15:0] hm;
        logic [4:0]  hn;
        bus.request_valid_in = 1'b0;
        set_all(0);

        repeat (3) @(negedge clk);
        check("rst.mask",  {16'h0, bus.suggested_waymask_out}, 32'hFFFF);
        check("rst.num",   {27'h0, bus.num_ways_out}, 32'd16);
        check("rst.busy",  {31'h0, bus.busy_out}, 32'h0);
        check("rst.valid", {31'h0, bus.waymask_valid_out}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rel.mask",  {16'h0, bus.suggested_waymask_out}, 32'hFFFF);
        check("rel.num",   {27'h0, bus.num_ways_out}, 32'd16);

        // All zero: total 0 -> k = 16 on first scan step.
        set_all(0);
        run("zero", 18, 16'hFFFF, 5'd16, 1'b0);

        // Single hot way -> k = 1.
        set_all(0);
        set_one(0, 100);
        run("hot1", 18, 16'h0001, 5'd1, 1'b0);

        // {50,30,10,5,5,0..}: 95*16 = 1520 >= 1500 at step 4.
        set_all(0);
        set_one(0, 50);
        set_one(1, 30);
        set_one(2, 10);
        set_one(3, 5);
        set_one(4, 5);
        run("desc", 21, 16'h000F, 5'd4, 1'b0);

        // Uniform 10s: 150*16 = 2400 = 160*15 at step 15.
        set_all(10);
        run("flat", 32, 16'h7FFF, 5'd15, 1'b0);

        // From k = 15 to k = 16: one-way change.
`ifdef AUTOCAT_WAYMASK_HYSTERESIS_EN
        hm = 16'h7FFF;
        hn = 5'd15;
`else
        hm = 16'hFFFF;
        hn = 5'd16;
`endif
        set_all(0);
        run("hyst", 18, hm, hn, 1'b0);

        // Extra request at T+5 (with new inputs) must be ignored.
        set_all(0);
        set_one(0, 100);
        run("poke", 18, 16'h0001, 5'd1, 1'b1);

        // Reset during SCAN aborts with no pulse.
        set_all(10);
        @(negedge clk);
        bus.request_valid_in = 1'b1;
        @(posedge clk);
        pulses = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) bus.request_valid_in = 1'b0;
            if (bus.waymask_valid_out === 1'b1) pulses++;
        end
        rst_n = 1'b0;
        #1;
        check("abort.busy",  {31'h0, bus.busy_out}, 32'h0);
        check("abort.mask",  {16'h0, bus.suggested_waymask_out}, 32'hFFFF);
        check("abort.num",   {27'h0, bus.num_ways_out}, 32'd16);
        check("abort.valid", {31'h0, bus.waymask_valid_out}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.waymask_valid_out === 1'b1) pulses++;
        end
        check("abort.pulses", pulses, 0);
        check("abort.idle",   {31'h0, bus.busy_out}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/autocat_waymask_calc.md
# autocat_waymask_calc

Downstream consumer of the AutoCAT hit-counter sorter. It snapshots the sorted per-way hit counters and sums them. It then finds the smallest way count `k` whose top-`k` counters cover a programmable fraction of all hits, and publishes a `k`-way contiguous waymask to the cache partitioning logic. It is a sequential, one-counter-per-cycle engine, so it needs no 16-input adder tree in the sorter's clock domain.

## Interface
- `CACHE_ASSOCIATIVITY`, 16: number of ways; a power of two, at least 2.
- `COUNTER_WIDTH`, 32: width of each sorted hit counter.
- `THRESHOLD_NUM`, 15: coverage target is `THRESHOLD_NUM/16`; legal range 1..16.
- `MIN_WAYS`, 1: lower clamp on `k`; legal range 1..`CACHE_ASSOCIATIVITY`.

Ports:
- `clk_in`, input, 1: the single clock.
- `reset_in`, input, 1: asynchronous, active-low reset.
- `sorted_counter_flatted_in`, input, `CACHE_ASSOCIATIVITY*COUNTER_WIDTH`: sorted counters in descending order; slice 0 holds the largest.
- `request_valid_in`, input, 1: start-calculation pulse.
- `busy_out`, output, 1: engine not idle.
- `waymask_valid_out`, output, 1: one-cycle pulse when a result is written.
- `suggested_waymask_out`, output, `CACHE_ASSOCIATIVITY`: low `k` bits set.
- `num_ways_out`, output, `$clog2(CACHE_ASSOCIATIVITY)+1`: the value `k`.

## Operation
- The FSM has four states: IDLE, SUM, SCAN, DONE.
- **IDLE:**
  - `request_valid_in` sampled high captures the full input vector into a snapshot register.
  - It also clears `total`, `running` and the index `i`, then moves to SUM.
- **SUM:**
  - Adds `snapshot[i]` to `total` and increments `i` each cycle, for `CACHE_ASSOCIATIVITY` cycles.
  - After the last element, `i` is cleared and the FSM moves to SCAN.
- **SCAN:**
  - Each cycle computes `running' = running + snapshot[i]` and `k = i+1`.
  - It terminates when `running'*16 >= total*THRESHOLD_NUM`, or when `i == CACHE_ASSOCIATIVITY-1`.
  - If `total == 0`, it terminates on its first cycle with `k = CACHE_ASSOCIATIVITY`.
  - On termination, `k` is clamped to `max(k, MIN_WAYS)` and latched, and the FSM moves to DONE.
- **DONE:**
  - Registers `num_ways_out = k` and `suggested_waymask_out = (1<<k)-1`.
  - Asserts `waymask_valid_out` for exactly one cycle, then returns to IDLE.
- Arithmetic widths:
  - `total` and `running` are `COUNTER_WIDTH+$clog2(CACHE_ASSOCIATIVITY)` bits wide.
  - The comparison is performed at that width plus 5 bits, so it cannot overflow.
- `busy_out` is high in SUM, SCAN and DONE, and low only in IDLE.
- `request_valid_in` is ignored while `busy_out` is high; requests are neither queued nor flagged.
- Input changes after the snapshot is taken do not affect the calculation in flight.
- Outputs hold their last result between calculations.

## Timing
- Reset values (asserted asynchronously):
  - `suggested_waymask_out` is all ones.
  - `num_ways_out = CACHE_ASSOCIATIVITY`.
  - `waymask_valid_out = 0` and `busy_out = 0`.
  - FSM in IDLE; snapshot and accumulators cleared.
- Request sampled at edge T:
  - SUM occupies cycles T+1 .. T+A, where A is `CACHE_ASSOCIATIVITY`.
  - SCAN occupies T+A+1 .. T+A+s, where s (1..A) is the termination step.
  - DONE is cycle T+A+s+1; the outputs and the valid pulse are visible in that cycle.
  - `busy_out` falls in cycle T+A+s+2.
- Best-case latency is A+2 cycles; worst-case is 2A+1 cycles.
- A new request is accepted earliest in the first IDLE cycle after DONE.
- Reset mid-calculation:
  - Aborts to IDLE immediately with no valid pulse.
  - Outputs return to their reset values.

## Configuration
- Macro: `AUTOCAT_WAYMASK_HYSTERESIS_EN`.
- Defined: in DONE, the outputs are updated only if `|k_new − num_ways_out| >= 2`; otherwise they keep their previous values. `waymask_valid_out` still pulses either way. This suppresses one-way oscillation.
- Undefined: every DONE overwrites the outputs unconditionally.

## Test plan
All scenarios use default parameters: `CACHE_ASSOCIATIVITY=16`, `THRESHOLD_NUM=15`, `MIN_WAYS=1`.
1. Deassert and release `reset_in` -> `suggested_waymask_out = 16'hFFFF`, `num_ways_out = 16`, `busy_out = 0`, `waymask_valid_out = 0`.
2. Counters {100, 0 × 15}, request at T -> `waymask_valid_out` high only at T+18; mask `16'h0001`, `num_ways_out = 1`.
3. All 16 counters = 10 (total 160, target running ≥ 150), request at T -> valid at T+32; mask `16'h7FFF`, `num_ways_out = 15`.
4. All counters 0 -> valid at T+18; mask `16'hFFFF`, `num_ways_out = 16`.
5. Second request at T+5 is ignored, with a single valid pulse only. Separately, `reset_in` low during SCAN -> no pulse, mask `16'hFFFF`, `busy_out = 0`.
6. Start from `num_ways_out = 15` (scenario 3), then run all counters 0 (new k = 16):
   - With the macro defined: mask stays `16'h7FFF` and the valid pulse still fires.
   - Without the macro: mask becomes `16'hFFFF`.
